// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Byte-serial load/store unit sitting between EX_MEM and MEM_WB.
//            Define MEM_STAGE_FW_EN to drive the fw_* forwarding port.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] mem_rd_data,
    input  logic [31:0] mem_store_data,
    input  logic        mem_load_enable,
    input  logic        mem_store_enable,
    input  logic [31:0] mem_load_store_addr,
    input  logic [2:0]  mem_funct3,
    input  logic [4:0]  mem_rd_addr,
    input  logic        mem_rd_write_enable,
    output logic [31:0] ram_addr,
    output logic [7:0]  ram_dout,
    output logic        ram_wr,
    input  logic [7:0]  ram_din,
    output logic [31:0] wb_rd_data,
    output logic [4:0]  wb_rd_addr,
    output logic        wb_rd_write_enable,
    output logic        stall_req,
    output logic        fw_write_enable,
    output logic [4:0]  fw_rd_addr,
    output logic [31:0] fw_rd_data
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_DONE   = 2'd2;

    logic [1:0]  r_state;
    logic [2:0]  r_k;
    logic [31:0] r_buf;
    logic [31:0] r_addr;
    logic [2:0]  r_funct3;
    logic [31:0] r_sdata;
    logic [4:0]  r_rd;
    logic        r_rd_we;
    logic        r_is_store;

    logic        w_mem_op;
    logic [2:0]  w_n_in;
    logic [2:0]  w_n_lat;
    logic [2:0]  w_issue_k;
    logic [7:0]  w_store_byte;
    logic [31:0] w_load_val;

    function automatic logic [2:0] f_nbytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   f_nbytes = 3'd1;
            2'b01:   f_nbytes = 3'd2;
            default: f_nbytes = 3'd4;
        endcase
    endfunction

    assign w_mem_op = mem_load_enable | mem_store_enable;
    assign w_n_in   = f_nbytes(mem_funct3);
    assign w_n_lat  = f_nbytes(r_funct3);

    // A load that is frozen, or already past its last issue, keeps re-reading
    // the previous byte so ram_din still holds that byte when capture happens.
    assign w_issue_k = (r_is_store || (rdy && (r_k < w_n_lat))) ? r_k : (r_k - 3'd1);

    always_comb begin
        case (r_k)
            3'd1:    w_store_byte = r_sdata[15:8];
            3'd2:    w_store_byte = r_sdata[23:16];
            3'd3:    w_store_byte = r_sdata[31:24];
            default: w_store_byte = r_sdata[7:0];
        endcase
    end

    always_comb begin
        case (r_funct3)
            3'b000:  w_load_val = {{24{r_buf[7]}}, r_buf[7:0]};
            3'b001:  w_load_val = {{16{r_buf[15]}}, r_buf[15:0]};
            3'b100:  w_load_val = {24'd0, r_buf[7:0]};
            3'b101:  w_load_val = {16'd0, r_buf[15:0]};
            default: w_load_val = r_buf;
        endcase
    end

    always_comb begin
        ram_addr           = 32'd0;
        ram_dout           = 8'd0;
        ram_wr             = 1'b0;
        stall_req          = 1'b0;
        wb_rd_data         = 32'd0;
        wb_rd_addr         = 5'd0;
        wb_rd_write_enable = 1'b0;
        case (r_state)
            c_IDLE: begin
                wb_rd_data = mem_rd_data;
                wb_rd_addr = mem_rd_addr;
                if (w_mem_op) begin
                    // Byte 0 goes out straight from the EX_MEM fields.
                    stall_req = 1'b1;
                    ram_addr  = mem_load_store_addr;
                    ram_dout  = mem_store_enable ? mem_store_data[7:0] : 8'd0;
                    ram_wr    = mem_store_enable & rdy & ~rst;
                end else begin
                    wb_rd_write_enable = mem_rd_write_enable;
                end
            end
            c_ACCESS: begin
                stall_req = 1'b1;
                ram_addr  = r_addr + {29'd0, w_issue_k};
                if (r_is_store) begin
                    ram_dout = w_store_byte;
                    ram_wr   = rdy & ~rst;
                end
            end
            c_DONE: begin
                wb_rd_data         = w_load_val;
                wb_rd_addr         = r_rd;
                wb_rd_write_enable = r_rd_we & ~r_is_store;
            end
            default: begin
                stall_req = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_k        <= 3'd0;
            r_buf      <= 32'd0;
            r_addr     <= 32'd0;
            r_funct3   <= 3'd0;
            r_sdata    <= 32'd0;
            r_rd       <= 5'd0;
            r_rd_we    <= 1'b0;
            r_is_store <= 1'b0;
        end else if (rdy) begin
            case (r_state)
                c_IDLE: begin
                    if (w_mem_op) begin
                        r_addr     <= mem_load_store_addr;
                        r_funct3   <= mem_funct3;
                        r_sdata    <= mem_store_data;
                        r_rd       <= mem_rd_addr;
                        r_rd_we    <= mem_rd_write_enable;
                        r_is_store <= mem_store_enable;
                        r_buf      <= 32'd0;
                        if (mem_store_enable && (w_n_in == 3'd1)) begin
                            r_state <= c_DONE;
                            r_k     <= 3'd0;
                        end else begin
                            r_state <= c_ACCESS;
                            r_k     <= 3'd1;
                        end
                    end
                end
                c_ACCESS: begin
                    if (r_is_store) begin
                        if (r_k == (w_n_lat - 3'd1)) begin
                            r_state <= c_DONE;
                            r_k     <= 3'd0;
                        end else begin
                            r_k <= r_k + 3'd1;
                        end
                    end else begin
                        case (r_k)
                            3'd1:    r_buf[7:0]   <= ram_din;
                            3'd2:    r_buf[15:8]  <= ram_din;
                            3'd3:    r_buf[23:16] <= ram_din;
                            3'd4:    r_buf[31:24] <= ram_din;
                            default: r_buf        <= r_buf;
                        endcase
                        if (r_k == w_n_lat) begin
                            r_state <= c_DONE;
                            r_k     <= 3'd0;
                        end else begin
                            r_k <= r_k + 3'd1;
                        end
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                    r_k     <= 3'd0;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_k     <= 3'd0;
                end
            endcase
        end
    end

`ifdef MEM_STAGE_FW_EN
    assign fw_write_enable = wb_rd_write_enable & ~stall_req;
    assign fw_rd_addr      = wb_rd_addr;
    assign fw_rd_data      = wb_rd_data;
`else
    assign fw_write_enable = 1'b0;
    assign fw_rd_addr      = 5'd0;
    assign fw_rd_data      = 32'd0;
`endif

endmodule
`default_nettype wire
